alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// - Shares one combinational alu instance between N_REQ requesters (e.g. an issue stage and a debug/test port).
// - Round-robin arbitration picks one requester; operands and operation are registered into the ALU.
// - The result and zero flag are captured and returned through a valid/ready response channel.
// - Sits between the requester masters and the alu instantiated next to it. The alu is not inside this block.
// PARAMETERS
// - N_REQ   2  number of requesters, 2..8
// - ID_W    1  requester index width, $clog2(N_REQ), minimum 1
// - CNT_W   8  width of each per-requester grant counter (used only with ALU_ARB_GRANT_CNT_EN)
// PORTS
// - clk            in   1            single clock, rising edge
// - rst_n          in   1            asynchronous, active-low reset
// - req_valid      in   N_REQ        requester i has an operation pending
// - req_ready      out  N_REQ        one-hot accept; req_valid[i] && req_ready[i] = transfer
// - req_op1        in   N_REQ*4      requester i operand 1, bits [4i+3:4i]
// - req_op2        in   N_REQ*4      requester i operand 2, same packing
// - req_operation  in   N_REQ x alu_operation_t   requester i operation (unpacked array)
// - alu_op1        out  4            to alu.op1
// - alu_op2        out  4            to alu.op2
// - alu_operation  out  alu_operation_t   to alu.operation
// - alu_result     in   4            from alu.result
// - alu_zero       in   1            from alu.zero
// - rsp_valid      out  1            response available
// - rsp_ready      in   1            consumer accepts the response
// - rsp_id         out  ID_W         index of the requester that owns the response
// - rsp_result     out  4            captured alu result
// - rsp_zero       out  1            captured alu zero flag
// - grant_cnt      out  N_REQ*CNT_W  per-requester accepted-op count (only with ALU_ARB_GRANT_CNT_EN)
// BEHAVIOUR
// - FSM states: IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
// - IDLE:
//   - grant = first i with req_valid[i], searching from rr_ptr upward (mod N_REQ).
//   - req_ready[grant] = 1 combinationally; all other bits are 0. All bits are 0 if no request.
//   - On transfer: latch op1, op2, operation and id into registers, then go to EXEC.
// - EXEC (1 cycle): the registers drive alu_*. alu_result/alu_zero are captured into rsp_*. rsp_valid <= 1. Go to RESP.
// - RESP: hold rsp_* stable until rsp_valid && rsp_ready.
//   - On that handshake: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod N_REQ, go to IDLE.
// - req_ready is 0 in EXEC and RESP. Requests wait there. There is no pipelining: at most 1 op in flight.
// - Latency: accept at cycle t -> rsp_valid high at t+2. Minimum 3 cycles per op when rsp_ready is held at 1.
// - alu_* outputs always reflect the operand registers. They hold their last value when not in EXEC.
// - Reset values:
//   - state = IDLE, rr_ptr = 0
//   - operand registers = 0, operation = ALU_ADD
//   - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0
//   - req_ready = 0, grant_cnt = 0
// - Reset mid-operation: the in-flight op is dropped and no response is issued. Requesters must re-present.
// - rr_ptr wraps from N_REQ-1 to 0. Index values >= N_REQ are never generated.
// - Requester behaviour: a requester may drop req_valid before it is accepted; it is then simply not granted.
//   Once accepted, its inputs are not sampled again.
// - rsp_ready may be high before rsp_valid; it has no effect outside RESP.
// CONFIGURATION
// - ALU_ARB_GRANT_CNT_EN defined:
//   - grant_cnt port exists. Counter i increments on each req_valid[i] && req_ready[i] transfer.
//   - Counters saturate at 2^CNT_W-1 and are cleared only by rst_n.
// - ALU_ARB_GRANT_CNT_EN undefined: the grant_cnt port and its counters are absent. All other behaviour is identical.
// TESTING
// - T1: after reset, req_valid=01, op1=3, op2=4, ALU_ADD, rsp_ready=1
//   -> req_ready=01 at t; rsp_valid at t+2 with id=0, result=7, zero=0.
// - T2: N_REQ=2, both valid continuously, requester 0 ALU_SUB 5-5, requester 1 ALU_XOR 9^6, rsp_ready=1
//   -> grants alternate 0,1,0,1; responses are result 0/zero=1 and 15/zero=0.
// - T3: RESP with rsp_ready=0 held 5 cycles
//   -> rsp_* stable, req_ready=00 throughout; the next grant comes 1 cycle after the rsp_ready pulse.
// - T4: ALU_ADD 9+8
//   -> result=1 (4-bit wrap), zero=0. ALU_LSL 1<<4 -> result=0, zero=1.
// - T5: assert rst_n=0 during EXEC -> rsp_valid=0 and req_ready=0 immediately; no response after release.
//   Then req_valid=10 -> grant 1 (rr_ptr=0 skips the idle requester 0).
// - T6 (ALU_ARB_GRANT_CNT_EN, CNT_W=2): 5 grants to requester 0 -> grant_cnt[0] reads 1,2,3,3,3.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 4-bit alu between N_REQ requesters.
// Optional per-requester saturating grant counters: define ALU_ARB_GRANT_CNT_EN.

package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LSL = 3'd5,
    ALU_LSR = 3'd6,
    ALU_SLT = 3'd7
  } alu_operation_t;
endpackage

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*4-1:0]     req_op1,
  input  logic [N_REQ*4-1:0]     req_op2,
  input  alu_operation_t         req_operation [N_REQ],
  output logic [3:0]             alu_op1,
  output logic [3:0]             alu_op2,
  output alu_operation_t         alu_operation,
  input  logic [3:0]             alu_result,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [3:0]             rsp_result,
  output logic                   rsp_zero
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

  generate
    if (N_REQ < 2 || N_REQ > 8 || CNT_W < 1 || ID_W < 1) begin : g_bad_params
      $error("alu_arbiter: unsupported parameter values");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_W:0] SUM_N  = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

  state_t          state_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] id_reg;
  logic [3:0]      op1_reg;
  logic [3:0]      op2_reg;
  alu_operation_t  operation_reg;
  logic            rsp_valid_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [3:0]      rsp_result_reg;
  logic            rsp_zero_reg;

  logic [N_REQ-1:0] rot_valid;
  logic             grant_found;
  logic [ID_W-1:0]  grant_pos;
  logic [ID_W:0]    grant_sum;
  logic [ID_W-1:0]  grant_idx;
  logic             accept;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the first
  // set bit is then the round-robin winner's offset from the pointer.
  assign rot_valid = N_REQ'({req_valid, req_valid} >> rr_ptr_reg);

  always_comb begin
    grant_found = 1'b0;
    grant_pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_pos   = ID_W'(k);
      end
    end
  end

  always_comb begin
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_pos};
    if (grant_sum >= SUM_N) begin
      grant_idx = ID_W'(grant_sum - SUM_N);
    end else begin
      grant_idx = ID_W'(grant_sum);
    end
  end

  assign accept = (state_reg == IDLE) && grant_found;

  // req_ready is gated by rst_n so it drops the moment reset is asserted.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      id_reg         <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      operation_reg  <= ALU_ADD;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op1_reg       <= req_op1[{grant_idx, 2'b00} +: 4];
            op2_reg       <= req_op2[{grant_idx, 2'b00} +: 4];
            operation_reg <= req_operation[grant_idx];
            id_reg        <= grant_idx;
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg <= alu_result;
          rsp_zero_reg   <= alu_zero;
          rsp_id_reg     <= id_reg;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= (rsp_id_reg == LAST) ? '0 : rsp_id_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_op1       = op1_reg;
  assign alu_op2       = op2_reg;
  assign alu_operation = operation_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_id        = rsp_id_reg;
  assign rsp_result    = rsp_result_reg;
  assign rsp_zero      = rsp_zero_reg;

`ifdef ALU_ARB_GRANT_CNT_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (req_valid[gi] && req_ready[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin / arithmetic reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 1;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*4-1:0] req_op1;
  logic [N*4-1:0] req_op2;
  alu_operation_t req_operation [N];
  logic [3:0]     alu_op1;
  logic [3:0]     alu_op2;
  alu_operation_t alu_operation;
  logic [3:0]     alu_result;
  logic           alu_zero;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [3:0]     rsp_result;
  logic           rsp_zero;
`ifdef ALU_ARB_GRANT_CNT_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_operation (req_operation),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_zero      (rsp_zero)
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  // The external alu that sits next to the arbiter.
  always_comb begin
    alu_result = 4'd0;
    case (alu_operation)
      ALU_ADD: alu_result = alu_op1 + alu_op2;
      ALU_SUB: alu_result = alu_op1 - alu_op2;
      ALU_AND: alu_result = alu_op1 & alu_op2;
      ALU_OR:  alu_result = alu_op1 | alu_op2;
      ALU_XOR: alu_result = alu_op1 ^ alu_op2;
      ALU_LSL: alu_result = alu_op1 << alu_op2;
      ALU_LSR: alu_result = alu_op1 >> alu_op2;
      ALU_SLT: alu_result = {3'b000, alu_op1 < alu_op2};
      default: alu_result = 4'd0;
    endcase
  end
  assign alu_zero = (alu_result == 4'd0);

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ptr = 0;
  int exp_cnt [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference alu written with plain integer arithmetic on 4-bit values.
  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (b >= 4) ? 0 : (a * (1 << b)) % 16;
      6: return a / (1 << b);
      7: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
    end
    return -1;
  endfunction

  // One complete transaction from the current IDLE cycle; stall = cycles
  // rsp_ready is held low once the response is up.
  task automatic run_txn(input int stall);
    int g, a, b, op, r;
    logic [N-1:0] oh;
    #1;
    g = pick(req_valid);
    oh = '0;
    if (g < 0) begin
      chk("idle_ready", req_ready, '0);
      return;
    end
    oh[g] = 1'b1;
    a  = int'(req_op1[g*4 +: 4]);
    b  = int'(req_op2[g*4 +: 4]);
    op = int'(req_operation[g]);
    r  = ref_alu(op, a, b);
    chk("grant", req_ready, oh);
    step();
    chk("exec_req_ready", req_ready, '0);
    chk("exec_rsp_valid", rsp_valid, 1'b0);
    chk("alu_op1", alu_op1, a);
    chk("alu_op2", alu_op2, b);
    chk("alu_operation", alu_operation, op);
`ifdef ALU_ARB_GRANT_CNT_EN
    exp_cnt[g] = (exp_cnt[g] < (1 << CW) - 1) ? exp_cnt[g] + 1 : exp_cnt[g];
    chk("grant_cnt", grant_cnt[g*CW +: CW], exp_cnt[g]);
`endif
    step();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_result", rsp_result, r);
    chk("rsp_zero", rsp_zero, (r == 0));
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      step();
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_result", rsp_result, r);
      chk("hold_id", rsp_id, g);
      chk("hold_req_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    step();
    chk("rsp_done", rsp_valid, 1'b0);
    exp_ptr = (g + 1) % N;
  endtask

  task automatic set_req(input int i, input alu_operation_t op, input int a, input int b);
    req_operation[i] = op;
    req_op1[i*4 +: 4] = a[3:0];
    req_op2[i*4 +: 4] = b[3:0];
  endtask

  initial begin
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    req_valid = '1;
    req_op1 = '0;
    req_op2 = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) req_operation[i] = ALU_ADD;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (3) step();
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_zero", rsp_zero, 1'b0);
    chk("rst_alu_op1", alu_op1, '0);
    chk("rst_alu_operation", alu_operation, ALU_ADD);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // T1: simple add.
    set_req(0, ALU_ADD, 3, 4);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    run_txn(0);

    // T2: both requesters contending, grants alternate.
    set_req(0, ALU_SUB, 5, 5);
    set_req(1, ALU_XOR, 9, 6);
    req_valid = 2'b11;
    repeat (4) run_txn(0);

    // T3: response back-pressure.
    run_txn(5);

    // T4: wrap and shift-out boundaries.
    set_req(0, ALU_ADD, 9, 8);
    req_valid = 2'b01;
    run_txn(0);
    set_req(0, ALU_LSL, 1, 4);
    run_txn(0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, alu_operation_t'($urandom_range(0, 7)), $urandom_range(0, 15),
                $urandom_range(0, 15));
      end
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      rsp_ready = 1'($urandom_range(0, 1));
      run_txn($urandom_range(0, 2));
    end

    // T5: reset while the op is executing.
    set_req(0, ALU_OR, 6, 1);
    set_req(1, ALU_AND, 7, 3);
    req_valid = 2'b11;
    #1;
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_req_ready", req_ready, '0);
    step();
    chk("t5_alu_op1", alu_op1, '0);
    rst_n = 1'b1;
    exp_ptr = 0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_no_rsp", rsp_valid, 1'b0);
    end
    req_valid = 2'b10;
    run_txn(0);

    // T6: five grants to requester 0 (counter saturation when enabled).
    set_req(0, ALU_SLT, 2, 9);
    req_valid = 2'b01;
    repeat (5) run_txn(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
